hilo_mdu_ctrl: RTL

//  Multiply/divide sequencer owning all HI/LO writes. Sits beside EX; accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO,

---
 rtl/hilo_mdu_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: multiply/divide sequencer driving HI/LO write ports with a restoring divider FSM.
// Optional MDU_ITER_MUL_EN: shift-add iterative multiply instead of a single-cycle product.
module hilo_mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              stall_req,
    output logic              busy,
    output logic              hi_we,
    output logic              lo_we,
    output logic [DATA_W-1:0] hi_wdata,
    output logic [DATA_W-1:0] lo_wdata
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] q, r, d, mag_a, mag_b, q_st, r_st;
    logic [DATA_W:0] r_sh;
    logic [2*DATA_W-1:0] p_nx;
    logic neg_q, neg_r, hi_sel, lo_sel, acc, last, ge, sa, sb, mul_fin;
    assign acc = op_valid && op <= 3'd5 && !flush;
    assign last = cnt == CW'(DATA_W - 1);
    assign sa = !op[0] && rs_data[DATA_W-1];
    assign sb = !op[0] && rt_data[DATA_W-1];
    assign mag_a = sa ? -rs_data : rs_data;
    assign mag_b = sb ? -rt_data : rt_data;
    // q holds the dividend bits still to shift in and collects quotient bits from the right
    assign r_sh = {r, q[DATA_W-1]};
    assign ge = r_sh >= {1'b0, d};
    assign r_st = ge ? DATA_W'(r_sh - {1'b0, d}) : r_sh[DATA_W-1:0];
    assign q_st = {q[DATA_W-2:0], ge};
`ifdef MDU_ITER_MUL_EN
    logic [DATA_W:0] sum;
    assign sum = {1'b0, r} + (q[0] ? {1'b0, d} : '0);
    assign p_nx = {sum, q[DATA_W-1:1]};
    assign mul_fin = last;
`else
    assign p_nx = {{DATA_W{1'b0}}, q} * {{DATA_W{1'b0}}, d};
    assign mul_fin = 1'b1;
`endif
    assign busy = state != IDLE;
    assign stall_req = (state == IDLE && acc && op <= 3'd3) || state == MUL || state == DIV;
    assign hi_we = state == DONE && hi_sel && !flush;
    assign lo_we = state == DONE && lo_sel && !flush;

    always_comb begin
        state_nx = state;
        if (flush) state_nx = IDLE;
        else unique case (state)
            IDLE:    state_nx = !acc ? IDLE : op[2] ? DONE : op[1] ? DIV : MUL;
            MUL:     state_nx = mul_fin ? DONE : MUL;
            DIV:     state_nx = last ? DONE : DIV;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            q <= '0;
            r <= '0;
            d <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_sel <= 1'b0;
            lo_sel <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
        end else begin
            state <= state_nx;
            if (!flush) unique case (state)
                IDLE: if (acc) begin
                    cnt <= '0;
                    hi_sel <= op != 3'd5;
                    lo_sel <= op != 3'd4;
                    if (op == 3'd4) hi_wdata <= rs_data;
                    else if (op == 3'd5) lo_wdata <= rs_data;
                    else begin
                        q <= mag_a;
                        d <= mag_b;
                        r <= '0;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    {r, q} <= p_nx;
                    if (mul_fin) {hi_wdata, lo_wdata} <= neg_q ? -p_nx : p_nx;
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    q <= q_st;
                    r <= r_st;
                    // divide-by-zero yields all-ones naturally; it skips the quotient sign fixup
                    if (last) begin
                        lo_wdata <= (d == '0 || !neg_q) ? q_st : -q_st;
                        hi_wdata <= neg_r ? -r_st : r_st;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
